// File: rtl/rcs_pkg.sv
// rcs_pkg: shared state type, default widths and modular-difference helper for ripple_count_sampler.
package rcs_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int CNT_W_D       = 4;
  localparam int ACC_W_D       = 16;
  localparam int PEND_W_D      = 8;
  localparam int SYNC_STAGES_D = 2;
  // Caller truncates the result to its own count width; the low bits are the modular difference.
  function automatic logic [31:0] mod_diff(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction
endpackage

// File: rtl/rcs_sync.sv
// rcs_sync: STAGES-deep multi-bit synchroniser with async active-low reset.
module rcs_sync
  import rcs_pkg::*;
#(
  parameter int W      = CNT_W_D,
  parameter int STAGES = SYNC_STAGES_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: filters a synchronised ripple count into step deltas, a running total and a valid/ready event stream.
// Optional RCS_MATCH_EN adds match_val/match_hit total comparison.
module ripple_count_sampler
  import rcs_pkg::*;
#(
  parameter int CNT_W       = CNT_W_D,
  parameter int ACC_W       = ACC_W_D,
  parameter int PEND_W      = PEND_W_D,
  parameter int SYNC_STAGES = SYNC_STAGES_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              clear,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [PEND_W-1:0] evt_delta,
  output logic [ACC_W-1:0]  total,
  output logic              ovf,
  output logic              locked
`ifdef RCS_MATCH_EN
  ,
  input  logic [ACC_W-1:0]  match_val,
  output logic              match_hit
`endif
);
  localparam int FILL = SYNC_STAGES + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  s, prev_q, prev_d, last_q, last_d, step;
  logic [PEND_W-1:0] pend_q, pend_d, pend_base, pend_add;
  logic [PEND_W:0]   pend_sum;
  logic [ACC_W-1:0]  total_q, total_d;
  logic              ovf_q, ovf_d, stable, warm, do_step, xfer, capture, sat;
  logic [2:0]        fill_q, fill_d;
  rcs_sync #(.W(CNT_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (count_in),
    .q   (s)
  );
  // Until the chain and prev hold post-reset samples, a match of s and prev means nothing.
  always_comb begin
    stable    = s == prev_q;
    warm      = fill_q == 3'(FILL);
    fill_d    = warm ? fill_q : fill_q + 3'd1;
    step      = CNT_W'(mod_diff(32'(s), 32'(last_q)));
    capture   = state_q == INIT && warm && stable;
    do_step   = state_q == RUN && stable && s != last_q;
    xfer      = evt_valid && evt_ready;
    prev_d    = s;
    state_d   = capture ? RUN : state_q;
    last_d    = (capture || do_step) ? s : last_q;
    pend_base = xfer ? '0 : pend_q;
    pend_add  = do_step ? PEND_W'(step) : '0;
    pend_sum  = {1'b0, pend_base} + {1'b0, pend_add};
    sat       = pend_sum > {1'b0, PEND_MAX};
    pend_d    = clear ? '0 : sat ? PEND_MAX : pend_sum[PEND_W-1:0];
    ovf_d     = !clear && (ovf_q || sat);
    total_d   = clear ? '0 : do_step ? total_q + ACC_W'(step) : total_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      prev_q  <= '0;
      last_q  <= '0;
      pend_q  <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      fill_q  <= fill_d;
    end
  end
  assign evt_valid = pend_q != '0;
  assign evt_delta = pend_q;
  assign total     = total_q;
  assign ovf       = ovf_q;
  assign locked    = state_q == RUN;
`ifdef RCS_MATCH_EN
  logic match_hit_q, match_hit_d;
  always_comb match_hit_d = !clear && do_step && total_d == match_val;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) match_hit_q <= 1'b0;
    else      match_hit_q <= match_hit_d;
  end
  assign match_hit = match_hit_q;
`endif
endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb_ripple_count_sampler: scenario tasks with a transfer scoreboard for ripple_count_sampler.
module tb_ripple_count_sampler;
  localparam int SYNC = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  count_in = 4'd0;
  logic        clear = 1'b0;
  logic        evt_ready = 1'b0;
  logic        evt_valid, ovf, locked;
  logic [7:0]  evt_delta;
  logic [15:0] total;
  logic [3:0]  cur;
  int          errors = 0;
  int          checks = 0;
  int          hits = 0;
  logic [7:0]  exp_q [$];
`ifdef RCS_MATCH_EN
  logic [15:0] match_val = 16'd4;
  logic        match_hit;
`endif

  ripple_count_sampler dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .clear     (clear),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_delta (evt_delta),
    .total     (total),
    .ovf       (ovf),
    .locked    (locked)
`ifdef RCS_MATCH_EN
    ,
    .match_val (match_val),
    .match_hit (match_hit)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: evt_delta=%0d, none expected", evt_delta);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (evt_delta !== e) begin
          errors++;
          $display("FAIL xfer_delta: evt_delta=%0d expected %0d", evt_delta, e);
        end
      end
    end
`ifdef RCS_MATCH_EN
    if (match_hit === 1'b1) hits++;
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cnt(input logic [3:0] v, input int n);
    count_in = v;
    cur = v;
    repeat (n) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_lock(input string name);
    int n = 0;
    while (locked !== 1'b1 && n < SYNC + 3) begin
      tick();
      n++;
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL %s: locked=%b after %0d edges, expected 1", name, locked, n);
    end
  endtask

  task automatic test_reset();
    cur = 4'd5;
    count_in = cur;
    rst = 1'b0;
    repeat (3) tick();
    checks += 3;
    if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b expected 0", locked); end
    if (total !== 16'd0) begin errors++; $display("FAIL rst_total: got %0d expected 0", total); end
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", evt_valid); end
    rst = 1'b1;
    wait_lock("lock_after_reset");
    repeat (4) tick();
    checks += 2;
    if (total !== 16'd0) begin errors++; $display("FAIL lock_total: got %0d expected 0", total); end
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL lock_valid: got %b expected 0", evt_valid); end
  endtask

  task automatic test_steps();
    set_cnt(4'd6, 10);
    set_cnt(4'd7, 10);
    checks += 3;
    if (total !== 16'd2) begin errors++; $display("FAIL steps_total: got %0d expected 2", total); end
    if (evt_delta !== 8'd2) begin errors++; $display("FAIL steps_delta: got %0d expected 2", evt_delta); end
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL steps_valid: got %b expected 1", evt_valid); end
  endtask

  task automatic test_wrap();
    set_cnt(4'd14, 10);
    do_clear();
    checks++;
    if (total !== 16'd0) begin errors++; $display("FAIL wrap_clear_total: got %0d expected 0", total); end
    evt_ready = 1'b1;
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd1);
    set_cnt(4'd15, 10);
    set_cnt(4'd0, 10);
    evt_ready = 1'b0;
    checks += 3;
    if (total !== 16'd2) begin errors++; $display("FAIL wrap_total: got %0d expected 2", total); end
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid: got %b expected 0", evt_valid); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_events: %0d transfers missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    set_cnt(4'd7, 10);
    do_clear();
    set_cnt(4'd6, 1);
    set_cnt(4'd8, 10);
    checks += 2;
    if (total !== 16'd1) begin errors++; $display("FAIL glitch_total: got %0d expected 1", total); end
    if (evt_delta !== 8'd1) begin errors++; $display("FAIL glitch_delta: got %0d expected 1", evt_delta); end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 300; i++) set_cnt(cur + 4'd1, 4);
    repeat (6) tick();
    checks += 3;
    if (evt_delta !== 8'd255) begin errors++; $display("FAIL sat_delta: got %0d expected 255", evt_delta); end
    if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", ovf); end
    if (total !== 16'd300) begin errors++; $display("FAIL sat_total: got %0d expected 300", total); end
    do_clear();
    checks += 3;
    if (total !== 16'd0) begin errors++; $display("FAIL clr_total: got %0d expected 0", total); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected 0", ovf); end
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b expected 0", evt_valid); end
  endtask

  task automatic test_mid_reset();
    rst = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL midrst_locked: got %b expected 0", locked); end
    count_in = cur + 4'd4;
    cur = count_in;
    repeat (3) tick();
    rst = 1'b1;
    wait_lock("lock_after_midrst");
    repeat (8) tick();
    checks += 2;
    if (total !== 16'd0) begin errors++; $display("FAIL midrst_total: got %0d expected 0", total); end
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", evt_valid); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    hits = 0;
    for (int i = 0; i < 3; i++) set_cnt(cur + 4'd1, 6);
    checks++;
    if (evt_delta !== 8'd3) begin errors++; $display("FAIL b2b_pre_delta: got %0d expected 3", evt_delta); end
    count_in = cur + 4'd1;
    cur = count_in;
    repeat (SYNC + 1) tick();
    evt_ready = 1'b1;
    exp_q.push_back(8'd3);
    tick();
    evt_ready = 1'b0;
    checks += 4;
    if (evt_delta !== 8'd1) begin errors++; $display("FAIL b2b_delta: got %0d expected 1", evt_delta); end
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", evt_valid); end
    if (total !== 16'd4) begin errors++; $display("FAIL b2b_total: got %0d expected 4", total); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_events: %0d transfers missing, expected 0", exp_q.size()); end
    repeat (4) tick();
`ifdef RCS_MATCH_EN
    checks++;
    if (hits != 1) begin errors++; $display("FAIL match_hit: got %0d pulses expected 1", hits); end
`endif
  endtask

  initial begin
    test_reset();
    test_steps();
    test_wrap();
    test_glitch();
    test_saturation();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
